psum_acc_sfp_feeder: RTL
========================

# psum_acc_sfp_feeder

Upstream feeder for the absolute-value normalisation SFP row. It accumulates partial-sum rows from the PE array output path into `col` saturating signed accumulators, one row per output vector. When a row completes, it sequences the SFP's two-step instruction protocol: acc (`inst=2'b10`), then div (`inst=2'b01`). It also exposes a valid/ready handshake that tells the consumer when the SFP outputs are stable.

## Interface
Parameters:
- `col`, 8, lanes per row
- `bw`, 8, operand width; used only to derive `bw_psum`
- `bw_psum`, `2*bw+4`, per-lane psum width (20)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  partial-sum row present
- `in_ready`  out  1  block accepts a row this cycle
- `in_data`  in  `col*bw_psum`  signed partial sums; lane i at `[bw_psum*(i+1)-1 : bw_psum*i]`
- `in_last`  in  1  accepted beat is the final partial for this row
- `sfp_in`  out  `col*bw_psum`  accumulated row; drives the SFP data input
- `inst`  out  2  SFP instruction: bit1 = acc, bit0 = div
- `sfp_valid`  out  1  SFP outputs hold a new normalised row
- `sfp_ready`  in  1  consumer has taken the SFP outputs
- `sat_flag`  out  1  some lane saturated in the row being presented; valid with `sfp_valid`
- `row_cnt`  out  16  rows issued to the SFP since reset; wraps

## Operation
- FSM states: ACCUM, LOAD, WAIT_OUT, DIVIDE.
- ACCUM
  - `in_ready=1`, `inst=00`.
  - A beat is accepted when `in_valid && in_ready`.
  - On the first accepted beat of a row (`first=1`), each accumulator is loaded with `sat(in_lane)` and the working saturation flag is cleared.
  - On later beats, each accumulator becomes `sat(acc + in_lane)`.
  - `first` clears on any accepted beat and sets when `in_last` is accepted.
  - Accepting `in_last` moves the FSM to LOAD.
- Saturation
  - The add is done in `bw_psum+1` bits.
  - The result is clamped to [`-(2^(bw_psum-1)-1)`, `2^(bw_psum-1)-1`], i.e. [-524287, 524287].
  - The clamp is symmetric so the SFP's two's-complement abs never overflows; a raw -524288 input clamps as well.
  - Any clamp sets the working saturation flag.
- `sfp_in` is driven directly from the accumulator registers. It stays stable from LOAD until the next row's first accepted beat.
- LOAD
  - `inst=10`, `in_ready=0`, lasting one cycle.
  - The SFP latches the abs values and the sum.
  - `row_cnt` increments.
  - Next state is DIVIDE if `out_pending` is 0, or if `sfp_valid && sfp_ready` this cycle; otherwise WAIT_OUT.
- WAIT_OUT
  - `inst=00`, `in_ready=0`.
  - Exits to DIVIDE on the cycle `sfp_valid && sfp_ready`.
- DIVIDE
  - `inst=01`, `in_ready=0`, lasting one cycle.
  - Sets `out_pending`.
  - Copies the working saturation flag into `sat_flag`.
  - Next state is ACCUM.
- Output handshake
  - `sfp_valid = out_pending`.
  - `out_pending` clears on `sfp_valid && sfp_ready`.
  - The next row may accumulate while `out_pending=1`; only DIVIDE is held back, because the SFP overwrites its outputs only on div.
- `inst=11` is never driven.

## Timing
- Reset values: FSM=ACCUM, accumulators=0, `first=1`, `out_pending=0`, `sat_flag=0`, `row_cnt=0`, `inst=00`, `sfp_valid=0`. `in_ready=1` from the first cycle after reset deasserts.
- Latency, with `in_last` accepted at edge N:
  - LOAD during cycle N+1
  - DIVIDE during N+2 when no output is pending
  - `sfp_valid=1` from N+3
- Minimum row period is 3 cycles for a single-beat row (ACCUM, LOAD, DIVIDE).
- `sfp_valid` stays high until handshaked. The handshake in the same cycle as DIVIDE is legal: `out_pending` stays set for the new row.
- `in_valid` while `in_ready=0`: ignored; the beat is not consumed.
- Reset asserted mid-row or in LOAD/WAIT_OUT/DIVIDE: next cycle state returns to reset values. The SFP's internal registers are not cleared; consumers ignore SFP outputs until `sfp_valid`.
- `row_cnt` wraps 65535 -> 0.

## Structure
- Package `sfp_feeder_pkg`:
  - FSM state enum
  - `INST_IDLE=2'b00`, `INST_ACC=2'b10`, `INST_DIV=2'b01`
  - `PSUM_MAX`/`PSUM_MIN` as functions of `bw_psum`
- Sub-module `psum_sat_add`: one combinational lane, with inputs acc, in, load, and outputs sum and sat. Instantiated `col` times by generate.
- Top holds the FSM, the accumulators, `out_pending`, the flags and `row_cnt`.

## Test plan
- Single beat, lanes {1,-1,2,-2,3,-3,4,-4} with `in_last` -> `in_ready` low 2 cycles, `inst` 10 then 01, `sfp_valid` at N+3; SFP lane0 output = 1048576/20 = 52428; `row_cnt=1`.
- Three beats, all lanes 100, `in_last` on the third -> every `sfp_in` lane = 300; `sat_flag=0`.
- Lane0 500000 twice, lane1 -500000 twice -> `sfp_in` lane0 = 524287, lane1 = -524287; `sat_flag=1`. Single beat of -524288 -> -524287, `sat_flag=1`.
- Hold `sfp_ready=0` and complete a second row -> LOAD issued, then `inst=00` in WAIT_OUT. Pulse `sfp_ready` -> DIVIDE on the same cycle; `sfp_valid` stays high for row 2.
- Assert `reset` during LOAD -> next cycle `inst=00`, `sfp_valid=0`, `row_cnt=0`. A following single-beat row of all lanes 7 behaves as a first row (no stale accumulation).
- `in_valid=1` with new data during LOAD/DIVIDE -> accumulators unchanged; the beat is accepted only after return to ACCUM.

Source files
------------

// File: rtl/sfp_feeder_pkg.sv
// rtl/sfp_feeder_pkg.sv - shared types and constants for the psum feeder
// Purpose: FSM state encoding, SFP instruction codes and psum clamp bounds.
// Ports: none (package).
package sfp_feeder_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WAIT_OUT = 2'd2,
        ST_DIVIDE   = 2'd3
    } feeder_state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_ACC  = 2'b10;
    localparam logic [1:0] INST_DIV  = 2'b01;

    // Symmetric clamp bounds so the SFP's two's-complement abs never overflows.
    function automatic int PSUM_MAX(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int PSUM_MIN(input int w);
        return -PSUM_MAX(w);
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - one combinational saturating accumulator lane
// Purpose: adds an incoming partial sum to the lane accumulator (or loads it
//          when i_load is set) and clamps to the symmetric psum range.
// Ports:
//   i_acc  : current accumulator value (signed)
//   i_in   : incoming partial sum (signed)
//   i_load : first beat of a row; ignore i_acc
//   o_sum  : clamped result
//   o_sat  : result was clamped
module psum_sat_add
    import sfp_feeder_pkg::*;
#(
    parameter int bw_psum = 20
) (
    input  logic signed [bw_psum-1:0] i_acc,
    input  logic signed [bw_psum-1:0] i_in,
    input  logic                      i_load,
    output logic        [bw_psum-1:0] o_sum,
    output logic                      o_sat
);

    localparam logic signed [bw_psum:0] L_MAX = (bw_psum + 1)'(PSUM_MAX(bw_psum));
    localparam logic signed [bw_psum:0] L_MIN = (bw_psum + 1)'(PSUM_MIN(bw_psum));

    logic signed [bw_psum:0] w_base;
    logic signed [bw_psum:0] w_full;

    // One extra bit of headroom: acc is already within the clamp range, so
    // acc + in can never wrap in bw_psum+1 bits.
    always_comb begin
        w_base = i_load ? '0 : {i_acc[bw_psum-1], i_acc};
        w_full = w_base + {i_in[bw_psum-1], i_in};
        o_sum  = w_full[bw_psum-1:0];
        o_sat  = 1'b0;
        if (w_full > L_MAX) begin
            o_sum = L_MAX[bw_psum-1:0];
            o_sat = 1'b1;
        end else if (w_full < L_MIN) begin
            o_sum = L_MIN[bw_psum-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/psum_acc_sfp_feeder.sv
// rtl/psum_acc_sfp_feeder.sv - psum row accumulator and SFP acc/div sequencer
// Purpose: accumulates partial-sum rows into col saturating lanes, then issues
//          the SFP acc and div instructions and tracks the output handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : partial-sum beat handshake; in_last ends a row
//   in_data             : col signed lanes of bw_psum bits
//   sfp_in              : accumulated row driven to the SFP
//   inst                : SFP instruction (bit1 acc, bit0 div)
//   sfp_valid/sfp_ready : SFP output handshake to the consumer
//   sat_flag            : a lane clamped in the presented row
//   row_cnt             : rows issued to the SFP since reset (wraps)
module psum_acc_sfp_feeder
    import sfp_feeder_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2 * bw + 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*bw_psum-1:0]   in_data,
    input  logic                     in_last,
    output logic [col*bw_psum-1:0]   sfp_in,
    output logic [1:0]               inst,
    output logic                     sfp_valid,
    input  logic                     sfp_ready,
    output logic                     sat_flag,
    output logic [15:0]              row_cnt
);

    feeder_state_t            r_state;
    logic [col*bw_psum-1:0]   r_acc;
    logic                     r_first;
    logic                     r_sat_work;
    logic                     r_out_pending;
    logic                     r_sat_flag;
    logic [15:0]              r_row_cnt;
    logic [1:0]               r_inst;
    logic                     r_in_ready;

    logic [col*bw_psum-1:0]   w_sum;
    logic [col-1:0]           w_lane_sat;
    logic                     w_accept;
    logic                     w_out_hs;

    assign w_accept = in_valid && r_in_ready;
    assign w_out_hs = r_out_pending && sfp_ready;

    for (genvar g = 0; g < col; g++) begin : g_lane
        psum_sat_add #(
            .bw_psum (bw_psum)
        ) u_lane (
            .i_acc  (r_acc[g*bw_psum +: bw_psum]),
            .i_in   (in_data[g*bw_psum +: bw_psum]),
            .i_load (r_first),
            .o_sum  (w_sum[g*bw_psum +: bw_psum]),
            .o_sat  (w_lane_sat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ACCUM;
            r_acc         <= '0;
            r_first       <= 1'b1;
            r_sat_work    <= 1'b0;
            r_out_pending <= 1'b0;
            r_sat_flag    <= 1'b0;
            r_row_cnt     <= 16'd0;
            r_inst        <= INST_IDLE;
            r_in_ready    <= 1'b1;
        end else begin
            // DIVIDE below overrides this, keeping the new row pending even if
            // the previous one is taken in the same cycle.
            if (w_out_hs) begin
                r_out_pending <= 1'b0;
            end
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc      <= w_sum;
                        r_first    <= in_last;
                        r_sat_work <= (r_first ? 1'b0 : r_sat_work) | (|w_lane_sat);
                        if (in_last) begin
                            r_state    <= ST_LOAD;
                            r_inst     <= INST_ACC;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    r_row_cnt <= r_row_cnt + 16'd1;
                    if (!r_out_pending || w_out_hs) begin
                        r_state <= ST_DIVIDE;
                        r_inst  <= INST_DIV;
                    end else begin
                        r_state <= ST_WAIT_OUT;
                        r_inst  <= INST_IDLE;
                    end
                end
                ST_WAIT_OUT: begin
                    // div overwrites the SFP outputs, so hold until consumed.
                    if (w_out_hs) begin
                        r_state <= ST_DIVIDE;
                        r_inst  <= INST_DIV;
                    end
                end
                ST_DIVIDE: begin
                    r_out_pending <= 1'b1;
                    r_sat_flag    <= r_sat_work;
                    r_state       <= ST_ACCUM;
                    r_inst        <= INST_IDLE;
                    r_in_ready    <= 1'b1;
                end
                default: begin
                    r_state    <= ST_ACCUM;
                    r_inst     <= INST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign sfp_in    = r_acc;
    assign inst      = r_inst;
    assign sfp_valid = r_out_pending;
    assign sat_flag  = r_sat_flag;
    assign row_cnt   = r_row_cnt;

endmodule
